// File: rtl/segment_decoder.sv
// Seven-segment pattern decoder: debounces qualified samples, accepts a pattern
// once it has been stable long enough, and presents it through a one-entry buffer.
module segment_decoder #(
   parameter int STABLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       seg_en,
   input  logic [7:0] seg_in,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] out_num,
   output logic       out_err,
   output logic [7:0] drop_cnt
);

   typedef enum logic [1:0] {IDLE, FILTER, LOCKED} state_t;

   localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

   state_t     state_q, state_d;
   logic [7:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic       valid_q, valid_d;
   logic [3:0] num_q, num_d;
   logic       err_q, err_d;
   logic [7:0] drop_q, drop_d;
   logic       accept;
   logic [3:0] dec_num;
   logic       dec_err;

   always_comb begin
      dec_num = 4'd0;
      dec_err = 1'b0;
      case (seg_in)
         8'h7E: dec_num = 4'h0;
         8'h30: dec_num = 4'h1;
         8'h6D: dec_num = 4'h2;
         8'h79: dec_num = 4'h3;
         8'h33: dec_num = 4'h4;
         8'h5B: dec_num = 4'h5;
         8'h5F: dec_num = 4'h6;
         8'h72: dec_num = 4'h7;
         8'h7F: dec_num = 4'h8;
         8'h7B: dec_num = 4'h9;
         8'h77: dec_num = 4'hA;
         8'h1F: dec_num = 4'hB;
         8'h4E: dec_num = 4'hC;
         8'h3D: dec_num = 4'hD;
         8'h4F: dec_num = 4'hE;
         8'h47: dec_num = 4'hF;
         default: dec_err = 1'b1;
      endcase
   end

   // Stability filter: candidate and counter only move on qualified samples.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      if (seg_en) begin
         if (state_q == IDLE || seg_in != cand_q) begin
            cand_d = seg_in;
            cnt_d  = 4'd1;
            if (STABLE_LIM == 4'd1) begin
               accept  = 1'b1;
               state_d = LOCKED;
            end else begin
               state_d = FILTER;
            end
         end else if (state_q == FILTER) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == STABLE_LIM) begin
               accept  = 1'b1;
               state_d = LOCKED;
            end
         end
      end
   end

   // Output buffer: an accept may replace a draining entry in the same cycle.
   always_comb begin
      valid_d = valid_q;
      num_d   = num_q;
      err_d   = err_q;
      drop_d  = drop_q;
      if (accept && (!valid_q || out_ready)) begin
         valid_d = 1'b1;
         num_d   = dec_num;
         err_d   = dec_err;
      end else begin
         if (accept && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
         if (valid_q && out_ready) begin
            valid_d = 1'b0;
            num_d   = 4'd0;
            err_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= 8'h00;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
         num_q   <= 4'd0;
         err_q   <= 1'b0;
         drop_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         num_q   <= num_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
      end
   end

   assign out_valid = valid_q;
   assign out_num   = num_q;
   assign out_err   = err_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_segment_decoder.sv
// Directed bench for segment_decoder with STABLE_CYCLES=3; outputs are
// checked 1 time unit after each rising edge.
module tb_segment_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       seg_en = 1'b0;
   logic [7:0] seg_in = 8'h00;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [3:0] out_num;
   logic       out_err;
   logic [7:0] drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   segment_decoder #(.STABLE_CYCLES(3)) dut (
      .clk(clk), .rst_n(rst_n), .seg_en(seg_en), .seg_in(seg_in),
      .out_ready(out_ready), .out_valid(out_valid), .out_num(out_num),
      .out_err(out_err), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic cyc(input logic en, input logic [7:0] s, input logic rdy);
      seg_en = en;
      seg_in = s;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if (out_valid !== 1'b0 || out_num !== 4'd0 || out_err !== 1'b0 || drop_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_outputs got v=%b n=%h e=%b d=%0d want 0 0 0 0", out_valid, out_num, out_err, drop_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_idle_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_basic();
      logic [4:0] ev = 5'b00100;
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 8'h6D, 1'b1);
         n_cmp++;
         if (out_valid !== ev[i]) begin
            n_bad++;
            $display("FAIL basic_valid sample %0d got %b want %b", i + 1, out_valid, ev[i]);
         end
         if (i == 2) begin
            n_cmp++;
            if (out_num !== 4'h2 || out_err !== 1'b0) begin
               n_bad++;
               $display("FAIL basic_data got n=%h e=%b want n=2 e=0", out_num, out_err);
            end
         end
      end
   endtask

   task automatic test_error_patterns();
      logic [5:0] ev = 6'b100100;
      logic [7:0] pat;
      for (int i = 0; i < 6; i++) begin
         pat = (i < 3) ? 8'h80 : 8'h00;
         cyc(1'b1, pat, 1'b1);
         n_cmp++;
         if (out_valid !== ev[i]) begin
            n_bad++;
            $display("FAIL err_valid sample %0d got %b want %b", i + 1, out_valid, ev[i]);
         end
         if (ev[i]) begin
            n_cmp++;
            if (out_num !== 4'h0 || out_err !== 1'b1) begin
               n_bad++;
               $display("FAIL err_data sample %0d got n=%h e=%b want n=0 e=1", i + 1, out_num, out_err);
            end
         end
      end
      cyc(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_glitch();
      logic [7:0] pats [6] = '{8'h30, 8'h30, 8'h79, 8'h30, 8'h30, 8'h30};
      logic [5:0] ev = 6'b100000;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b1, pats[i], 1'b1);
         n_cmp++;
         if (out_valid !== ev[i]) begin
            n_bad++;
            $display("FAIL glitch_valid sample %0d got %b want %b", i + 1, out_valid, ev[i]);
         end
      end
      n_cmp++;
      if (out_num !== 4'h1 || out_err !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch_data got n=%h e=%b want n=1 e=0", out_num, out_err);
      end
      cyc(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_backpressure_drop();
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h7E, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_num !== 4'h0 || out_err !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_first got v=%b n=%h e=%b want 1 0 0", out_valid, out_num, out_err);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'h4F, 1'b0);
         n_cmp++;
         if (out_valid !== 1'b1 || out_num !== 4'h0 || out_err !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold sample %0d got v=%b n=%h e=%b want 1 0 0", i + 1, out_valid, out_num, out_err);
         end
      end
      n_cmp++;
      if (drop_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL bp_drop_cnt got %0d want 1", drop_cnt);
      end
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0 || out_num !== 4'h0) begin
         n_bad++;
         $display("FAIL bp_drain got v=%b n=%h want 0 0", out_valid, out_num);
      end
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_after_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'h33, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_num !== 4'h4) begin
         n_bad++;
         $display("FAIL b2b_first got v=%b n=%h want 1 4", out_valid, out_num);
      end
      cyc(1'b1, 8'h5F, 1'b0);
      cyc(1'b1, 8'h5F, 1'b0);
      cyc(1'b1, 8'h5F, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b1 || out_num !== 4'h6 || drop_cnt !== 8'd1) begin
         n_bad++;
         $display("FAIL b2b_reload got v=%b n=%h d=%0d want 1 6 1", out_valid, out_num, drop_cnt);
      end
      cyc(1'b0, 8'h00, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_qualifier();
      logic [5:0] en = 6'b100101;
      logic [5:0] ev = 6'b100000;
      for (int i = 0; i < 6; i++) begin
         cyc(en[i], 8'h77, 1'b1);
         n_cmp++;
         if (out_valid !== ev[i]) begin
            n_bad++;
            $display("FAIL qual_valid cycle %0d got %b want %b", i + 1, out_valid, ev[i]);
         end
      end
      n_cmp++;
      if (out_num !== 4'hA || out_err !== 1'b0) begin
         n_bad++;
         $display("FAIL qual_data got n=%h e=%b want n=a e=0", out_num, out_err);
      end
      cyc(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_drop_saturate();
      logic [7:0] pat;
      for (int k = 0; k < 260; k++) begin
         pat = (k % 2 == 1) ? 8'h30 : 8'h7E;
         for (int i = 0; i < 3; i++) cyc(1'b1, pat, 1'b0);
         if (k == 100) begin
            n_cmp++;
            if (drop_cnt !== 8'd101) begin
               n_bad++;
               $display("FAIL sat_mid got %0d want 101", drop_cnt);
            end
         end
      end
      n_cmp++;
      if (drop_cnt !== 8'd255 || out_valid !== 1'b1 || out_num !== 4'h0) begin
         n_bad++;
         $display("FAIL sat_end got d=%0d v=%b n=%h want 255 1 0", drop_cnt, out_valid, out_num);
      end
   endtask

   task automatic test_midreset();
      logic [2:0] ev = 3'b100;
      cyc(1'b1, 8'h5B, 1'b0);
      cyc(1'b1, 8'h5B, 1'b0);
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if (out_valid !== 1'b0 || out_num !== 4'd0 || out_err !== 1'b0 || drop_cnt !== 8'd0) begin
         n_bad++;
         $display("FAIL midreset_async got v=%b n=%h e=%b d=%0d want 0 0 0 0", out_valid, out_num, out_err, drop_cnt);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 8'h5B, 1'b1);
         n_cmp++;
         if (out_valid !== ev[i]) begin
            n_bad++;
            $display("FAIL midreset_valid sample %0d got %b want %b", i + 1, out_valid, ev[i]);
         end
      end
      n_cmp++;
      if (out_num !== 4'h5 || out_err !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_data got n=%h e=%b want n=5 e=0", out_num, out_err);
      end
      cyc(1'b1, 8'h5B, 1'b1);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL midreset_once got %b want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error_patterns();
      test_glitch();
      test_backpressure_drop();
      test_back_to_back();
      test_qualifier();
      test_drop_saturate();
      test_midreset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/segment_decoder.md
SEGMENT_DECODER -- requirements
Module: segment_decoder

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, 3, number of consecutive identical qualified samples required to accept a pattern (legal range 1..15).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port: seg_en  input  1  sample qualifier; seg_in is examined only on cycles with seg_en=1.
REQ-005 SHALL have port: seg_in  input  8  segment pattern, bit7 = blank/error flag, bits6..0 = segments a..g.
REQ-006 SHALL have port: out_ready  input  1  consumer ready.
REQ-007 SHALL have port: out_valid  output  1  decoded character available.
REQ-008 SHALL have port: out_num  output  4  decoded hex digit.
REQ-009 SHALL have port: out_err  output  1  pattern not recognised.
REQ-010 SHALL have port: drop_cnt  output  8  count of accepted characters lost to backpressure.

Function
REQ-011 SHALL decode patterns as 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:72 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47 (hex, full 8 bits).
REQ-012 SHALL decode any other pattern, including any with bit7=1 and 0x00, as out_num=0, out_err=1.
REQ-013 SHALL hold a candidate register (8 bits) and a stability counter (4 bits), both frozen on cycles with seg_en=0.
REQ-014 SHALL implement states IDLE (no candidate), FILTER (candidate counting) and LOCKED (candidate already accepted).
REQ-015 On a qualified sample differing from the candidate, or any qualified sample in IDLE: candidate<=seg_in, counter<=1, state<=FILTER.
REQ-016 On a qualified sample equal to the candidate in FILTER: counter increments; when the counter reaches STABLE_CYCLES the sample is an accept event and state<=LOCKED.
REQ-017 With STABLE_CYCLES=1, the first qualified sample of a new pattern SHALL itself be the accept event and go directly to LOCKED.
REQ-018 In LOCKED, qualified samples equal to the candidate SHALL produce no event; a held pattern is accepted exactly once.
REQ-019 The output SHALL be a one-entry buffer; an accept event loads it and out_valid rises on the clock edge following the accepting sample (latency one cycle after the STABLE_CYCLES-th identical sample).
REQ-020 A transfer occurs on a cycle with out_valid=1 and out_ready=1; out_valid falls after it unless a new event loads in the same cycle.
REQ-021 Accept event coincident with a transfer SHALL load the new entry with out_valid staying 1 (no bubble).
REQ-022 Accept event while out_valid=1 and out_ready=0 SHALL be dropped, leaving the buffer unchanged, and drop_cnt increments, saturating at 255.
REQ-023 out_num and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 With out_valid=0, out_num and out_err SHALL be 0.

Reset
REQ-025 rst_n=0 SHALL immediately force out_valid=0, out_num=0, out_err=0, drop_cnt=0, candidate=0x00, counter=0, state=IDLE, regardless of clk.
REQ-026 Reset mid-operation SHALL discard any partial filter count and any buffered character; after release, STABLE_CYCLES fresh qualified samples are required.

Verification
REQ-027 STABLE_CYCLES=3, seg_en=1, out_ready=1, seg_in=0x6D for 5 cycles -> one out_valid pulse one cycle after the 3rd sample, out_num=2, out_err=0, no second pulse.
REQ-028 seg_in=0x80 for 3 samples, then 0x00 for 3 samples -> two characters, each out_num=0, out_err=1.
REQ-029 seg_in 0x30,0x30,0x79,0x30,0x30,0x30 -> exactly one character, out_num=1, one cycle after the 6th sample; nothing for 0x79.
REQ-030 out_ready=0: accept 0x7E, then accept 0x4F -> out_num stays 0, drop_cnt=1; raise out_ready -> one transfer of 0, then out_valid=0.
REQ-031 seg_in=0x77 with seg_en pattern 1,0,1,0,0,1 -> accept on the third qualified sample, out_num=A; unqualified cycles change nothing.
REQ-032 Two qualified samples of 0x5B, then rst_n=0 between edges -> outputs 0 immediately; after release, 0x5B needs 3 new samples before out_num=5 appears.
